// File: rtl/snn_readout_pkg.sv
// Shared types and helpers for the SNN spike readout: FSM states, saturating add, popcount.
package snn_readout_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Helpers work on fixed-width containers; callers cast to their own widths.
  localparam int MAX_SCORE_W = 32;
  localparam int MAX_G       = 512;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  function automatic int unsigned popcount(input logic [MAX_G-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_G; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/snn_spike_readout_if.sv
// Step input and classification result handshake of the spike readout.
interface snn_spike_readout_if #(
  parameter int N       = 96,
  parameter int C       = 4,
  parameter int SCORE_W = 16
);
  localparam int ID_W = (C > 1) ? $clog2(C) : 1;

  logic               step_valid;
  logic [N-1:0]       spikes_vec;
  logic               class_valid;
  logic               class_ready;
  logic [ID_W-1:0]    class_id;
  logic [SCORE_W-1:0] class_score;

  modport master (
    output step_valid, spikes_vec, class_ready,
    input  class_valid, class_id, class_score
  );

  modport slave (
    input  step_valid, spikes_vec, class_ready,
    output class_valid, class_id, class_score
  );
endinterface

// File: rtl/snn_group_popcount.sv
// Counts the set bits of one class's contiguous neuron group.
module snn_group_popcount
  import snn_readout_pkg::*;
#(
  parameter  int G  = 24,
  localparam int CW = $clog2(G + 1)
) (
  input  logic [G-1:0]  grp,
  output logic [CW-1:0] cnt
);

  generate
    if (G < 1 || G > MAX_G) begin : g_bad_group
      $error("snn_group_popcount: G out of supported range");
    end
  endgenerate

  assign cnt = CW'(popcount(MAX_G'(grp)));

endmodule

// File: rtl/snn_spike_readout.sv
// Per-class spike accumulation over T_WIN steps, sequential argmax, valid/ready result.
// Optional per-neuron counters behind `SNN_READOUT_NEURON_CNT_EN.
module snn_spike_readout
  import snn_readout_pkg::*;
#(
  parameter  int N       = 96,
  parameter  int C       = 4,
  parameter  int T_WIN   = 100,
  parameter  int SCORE_W = 16,
  localparam int AW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  snn_spike_readout_if.slave  bus,
  output logic                busy,
  output logic                drop_flag,
  input  logic [AW-1:0]       rd_addr,
  output logic [SCORE_W-1:0]  rd_data
);

  localparam int G    = N / C;
  localparam int CW   = $clog2(G + 1);
  localparam int ID_W = (C > 1) ? $clog2(C) : 1;
  localparam int SCW  = $clog2(T_WIN + 1);
  localparam logic [SCW-1:0]  LAST_STEP = SCW'(T_WIN - 1);
  localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(C - 1);

  generate
    if (N % C != 0) begin : g_bad_nc
      $error("snn_spike_readout: N must be a multiple of C");
    end
    if (T_WIN < 1) begin : g_bad_twin
      $error("snn_spike_readout: T_WIN must be at least 1");
    end
    if (SCORE_W > MAX_SCORE_W) begin : g_bad_score_w
      $error("snn_spike_readout: SCORE_W exceeds 32");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [SCW-1:0]     step_cnt_reg, step_cnt_next;
  logic [SCORE_W-1:0] score_reg [C];
  logic [SCORE_W-1:0] score_next [C];
  logic [SCORE_W-1:0] score_sum [C];
  logic [CW-1:0]      grp_cnt [C];
  logic [ID_W-1:0]    idx_reg, idx_next;
  logic [ID_W-1:0]    best_id_reg, best_id_next, cand_id;
  logic [SCORE_W-1:0] best_score_reg, best_score_next, cand_score;
  logic               class_valid_reg, class_valid_next;
  logic [ID_W-1:0]    class_id_reg, class_id_next;
  logic [SCORE_W-1:0] class_score_reg, class_score_next;
  logic               drop_flag_reg, drop_flag_next;

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_class
      snn_group_popcount #(.G(G)) u_popcount (
        .grp (bus.spikes_vec[gi*G +: G]),
        .cnt (grp_cnt[gi])
      );
      assign score_sum[gi] = SCORE_W'(sat_add(32'(score_reg[gi]), 32'(grp_cnt[gi]), SCORE_W));
    end
  endgenerate

  // Strictly-greater keeps the earlier (lower) index on ties.
  always_comb begin
    cand_id    = best_id_reg;
    cand_score = best_score_reg;
    if (score_reg[idx_reg] > best_score_reg) begin
      cand_id    = idx_reg;
      cand_score = score_reg[idx_reg];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    step_cnt_next    = step_cnt_reg;
    idx_next         = idx_reg;
    best_id_next     = best_id_reg;
    best_score_next  = best_score_reg;
    class_valid_next = class_valid_reg;
    class_id_next    = class_id_reg;
    class_score_next = class_score_reg;
    drop_flag_next   = drop_flag_reg;
    for (int c = 0; c < C; c++) begin
      score_next[c] = score_reg[c];
    end

    case (state_reg)
      ACCUM: begin
        if (bus.step_valid) begin
          for (int c = 0; c < C; c++) begin
            score_next[c] = score_sum[c];
          end
          if (step_cnt_reg == LAST_STEP) begin
            step_cnt_next   = '0;
            state_next      = SCAN;
            idx_next        = '0;
            best_id_next    = '0;
            best_score_next = score_sum[0];
          end else begin
            step_cnt_next = step_cnt_reg + 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.step_valid) drop_flag_next = 1'b1;
        best_id_next    = cand_id;
        best_score_next = cand_score;
        if (idx_reg == LAST_IDX) begin
          state_next       = DONE;
          class_valid_next = 1'b1;
          class_id_next    = cand_id;
          class_score_next = cand_score;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (bus.step_valid) drop_flag_next = 1'b1;
        if (bus.class_ready) begin
          class_valid_next = 1'b0;
          state_next       = ACCUM;
          for (int c = 0; c < C; c++) begin
            score_next[c] = '0;
          end
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step_cnt_reg    <= '0;
      idx_reg         <= '0;
      best_id_reg     <= '0;
      best_score_reg  <= '0;
      class_valid_reg <= 1'b0;
      class_id_reg    <= '0;
      class_score_reg <= '0;
      drop_flag_reg   <= 1'b0;
      for (int c = 0; c < C; c++) begin
        score_reg[c] <= '0;
      end
    end else begin
      step_cnt_reg    <= step_cnt_next;
      idx_reg         <= idx_next;
      best_id_reg     <= best_id_next;
      best_score_reg  <= best_score_next;
      class_valid_reg <= class_valid_next;
      class_id_reg    <= class_id_next;
      class_score_reg <= class_score_next;
      drop_flag_reg   <= drop_flag_next;
      for (int c = 0; c < C; c++) begin
        score_reg[c] <= score_next[c];
      end
    end
  end

  assign bus.class_valid = class_valid_reg;
  assign bus.class_id    = class_id_reg;
  assign bus.class_score = class_score_reg;
  assign busy            = (state_reg != ACCUM);
  assign drop_flag       = drop_flag_reg;

`ifdef SNN_READOUT_NEURON_CNT_EN
  logic [SCORE_W-1:0] cnt_reg [N];
  logic               cnt_inc, cnt_clr;

  assign cnt_inc = (state_reg == ACCUM) && bus.step_valid;
  assign cnt_clr = (state_reg == DONE) && bus.class_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < N; i++) cnt_reg[i] <= '0;
    end else if (cnt_inc) begin
      for (int i = 0; i < N; i++) begin
        cnt_reg[i] <= SCORE_W'(sat_add(32'(cnt_reg[i]), {31'd0, bus.spikes_vec[i]}, SCORE_W));
      end
    end
  end

  assign rd_data = (int'(rd_addr) < N) ? cnt_reg[rd_addr] : '0;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule
